// File: rtl/alu_seq_if.sv
// Handshake and data bundle for alu_seq: operand side, result side and busy flag.
interface alu_seq_if #(parameter int W = 16);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] Ain;
  logic [W-1:0] Bin;
  logic [2:0]   ALUop;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic [3:0]   status;
  logic         busy;

  modport master (
    output in_valid, Ain, Bin, ALUop, out_ready,
    input  in_ready, out_valid, out, status, busy
  );

  modport slave (
    input  in_valid, Ain, Bin, ALUop, out_ready,
    output in_ready, out_valid, out, status, busy
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: W-bit handshaked ALU with registered result and {C,Z,N,V} status.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier for op 111.
//
// state | meaning
// IDLE  | accepting ops; single-cycle ops retire here
// BUSY  | shift-add multiply, one multiplier bit per cycle
module alu_seq #(parameter int W = 16) (
  input logic      clk,
  input logic      reset_n,
  alu_seq_if.slave bus
);
  localparam int SW = $clog2(W);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_ASR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [W-1:0]    a, b;
  logic [SW-1:0]   amt;
  logic [W:0]      add_w, sub_w, shl_w, shr_w;
  logic signed [W:0] asr_w;
  logic [W-1:0]    alu_res;
  logic            alu_c, alu_v;

  logic [W-1:0]    out_q, out_d;
  logic [3:0]      status_q, status_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_w, accept;

  assign a = bus.Ain;
  assign b = bus.Bin;

  // Shifts carry one extra bit so the last bit shifted out lands in the spare position.
  always_comb begin
    amt   = b[SW-1:0];
    add_w = {1'b0, a} + {1'b0, b};
    sub_w = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    shl_w = {1'b0, a} << amt;
    shr_w = {a, 1'b0} >> amt;
    asr_w = $signed({a, 1'b0}) >>> amt;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.ALUop)
      OP_ADD: begin
        alu_res = add_w[W-1:0];
        alu_c   = add_w[W];
        alu_v   = (a[W-1] == b[W-1]) && (add_w[W-1] != a[W-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[W-1:0];
        alu_c   = sub_w[W];
        alu_v   = (a[W-1] != b[W-1]) && (sub_w[W-1] != a[W-1]);
      end
      OP_AND: alu_res = a & b;
      OP_NOT: alu_res = ~b;
      OP_SHL: begin
        alu_res = shl_w[W-1:0];
        alu_c   = shl_w[W];
      end
      OP_SHR: begin
        alu_res = shr_w[W:1];
        alu_c   = shr_w[0];
      end
      OP_ASR: begin
        alu_res = asr_w[W:1];
        alu_c   = asr_w[0];
      end
      OP_MUL: alu_res = '0;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [SW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_step;

  // prod holds {partial sum, remaining multiplier bits}; each step adds and shifts right.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
    mul_step = {mul_sum, prod_q[W-1:1]};
  end

  assign busy_w = (state_q == BUSY);
`else
  assign busy_w = 1'b0;
`endif

  assign bus.in_ready  = !busy_w && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.busy      = busy_w;
  assign bus.out       = out_q;
  assign bus.status    = status_q;
  assign bus.out_valid = out_valid_q;

  always_comb begin
    out_d       = out_q;
    status_d    = status_q;
    out_valid_d = out_valid_q && !bus.out_ready;
`ifdef ALU_SEQ_MUL_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    if (accept && bus.ALUop == OP_MUL) begin
      state_d = BUSY;
      cnt_d   = SW'(W-1);
      prod_d  = {{W{1'b0}}, b};
      mcand_d = a;
    end else if (accept) begin
`else
    if (accept) begin
`endif
      out_d       = alu_res;
      status_d    = {alu_c, (alu_res == '0), alu_res[W-1], alu_v};
      out_valid_d = 1'b1;
    end
`ifdef ALU_SEQ_MUL_EN
    if (state_q == BUSY) begin
      prod_d = mul_step;
      cnt_d  = cnt_q - {{(SW-1){1'b0}}, 1'b1};
      if (cnt_q == '0) begin
        state_d     = IDLE;
        out_d       = mul_step[W-1:0];
        status_d    = {1'b0, (mul_step[W-1:0] == '0), mul_step[W-1], (mul_step[2*W-1:W] != '0)};
        out_valid_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q       <= '0;
      status_q    <= '0;
      out_valid_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
`endif
    end else begin
      out_q       <= out_d;
      status_q    <= status_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_SEQ_MUL_EN
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results are queued at accept and
// popped by a monitor whenever a result is handed over.
module tb_alu_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [W+3:0] exp_q[$];

  alu_seq_if #(.W(W)) bus ();
  alu_seq #(.W(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: a result is consumed on the edge following a negedge with valid && ready.
  initial begin
    logic [W+3:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {12'h0, bus.out, bus.status}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("result", {12'h0, bus.out, bus.status}, {12'h0, e});
        end
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] eo, input logic [3:0] es, input bit push);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.ALUop    = op;
    bus.Ain      = av;
    bus.Bin      = bv;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("issue_timeout", 32'd0, 32'd1);
    @(posedge clk);
    if (push) exp_q.push_back({eo, es});
    #1 bus.in_valid = 1'b0;
  endtask

  initial begin
    int  n;
    bit  bad_a, bad_b, bad_c;
    bus.in_valid  = 1'b0;
    bus.Ain       = '0;
    bus.Bin       = '0;
    bus.ALUop     = 3'b000;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    check("rst_out", bus.out, 0);
    check("rst_status", bus.status, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk) #1;

    // single-cycle ops, back to back with out_ready held high
    issue(3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011, 1);
    issue(3'b001, 16'h0005, 16'h0005, 16'h0000, 4'b1100, 1);
    issue(3'b001, 16'h0003, 16'h0005, 16'hFFFE, 4'b0010, 1);
    issue(3'b110, 16'h8000, 16'h0004, 16'hF800, 4'b0010, 1);
    issue(3'b100, 16'h8001, 16'h0001, 16'h0002, 4'b1000, 1);
    issue(3'b101, 16'h0001, 16'h0010, 16'h0001, 4'b0000, 1);
    issue(3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1);
    issue(3'b011, 16'h1234, 16'h00FF, 16'hFF00, 4'b0010, 1);
    issue(3'b000, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100, 1);
    issue(3'b101, 16'h8003, 16'h0001, 16'h4001, 4'b1000, 1);
    issue(3'b110, 16'h8001, 16'h000F, 16'hFFFF, 4'b0010, 1);
    issue(3'b001, 16'h8000, 16'h0001, 16'h7FFF, 4'b1001, 1);
    issue(3'b100, 16'h4000, 16'h0002, 16'h0000, 4'b1100, 1);

`ifdef ALU_SEQ_MUL_EN
    issue(3'b111, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 1);
    n = 0;
    bad_a = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
      if (bus.in_ready) bad_a = 1'b1;
    end
    check("mul_busy_cycles", n, W);
    check("mul_in_ready_low", {31'd0, bad_a}, 0);
    check("mul_out_valid", bus.out_valid, 1);
    @(posedge clk) #1;
    issue(3'b111, 16'h0100, 16'h0100, 16'h0000, 4'b0101, 1);
    issue(3'b111, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0001, 1);
    issue(3'b000, 16'h0000, 16'h0000, 16'h0000, 4'b0100, 1);
    issue(3'b111, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0001, 1);
`else
    issue(3'b111, 16'h0003, 16'h0005, 16'h0000, 4'b0100, 1);
    @(negedge clk);
    check("mul_off_busy", bus.busy, 0);
    @(posedge clk) #1;
`endif

    // back-pressure: ADD result held while AND waits
    bus.out_ready = 1'b0;
    issue(3'b000, 16'h0002, 16'h0003, 16'h0005, 4'b0000, 1);
    bus.in_valid = 1'b1;
    bus.ALUop    = 3'b010;
    bus.Ain      = 16'h00FF;
    bus.Bin      = 16'h0F0F;
    bad_a = 1'b0;
    bad_b = 1'b0;
    bad_c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.out !== 16'h0005 || bus.status !== 4'b0000) bad_a = 1'b1;
      if (bus.in_ready !== 1'b0) bad_b = 1'b1;
      if (bus.out_valid !== 1'b1) bad_c = 1'b1;
    end
    check("hold_stable", {31'd0, bad_a}, 0);
    check("hold_in_ready_low", {31'd0, bad_b}, 0);
    check("hold_out_valid", {31'd0, bad_c}, 0);
    @(posedge clk) #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_release", bus.in_ready, 1);
    exp_q.push_back({16'h000F, 4'b0000});
    @(posedge clk) #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check("bp_and_out", bus.out, 16'h000F);
    check("bp_and_valid", bus.out_valid, 1);
    @(posedge clk) #1 bus.out_ready = 1'b1;
    @(posedge clk) #1;

    // asynchronous reset in the middle of an operation
`ifdef ALU_SEQ_MUL_EN
    issue(3'b111, 16'h0003, 16'h0005, 16'h0000, 4'b0000, 0);
    repeat (5) @(negedge clk);
    check("pre_rst_busy", bus.busy, 1);
`else
    bus.out_ready = 1'b0;
    issue(3'b000, 16'h8001, 16'h8002, 16'h0000, 4'b0000, 0);
    @(negedge clk);
    check("pre_rst_valid", bus.out_valid, 1);
`endif
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_out", bus.out, 0);
    check("mid_rst_status", bus.status, 0);
    bus.out_ready = 1'b1;
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk) #1;
    issue(3'b000, 16'h0001, 16'h0001, 16'h0002, 4'b0000, 1);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
